// File: rtl/spiking_rate_decoder.sv
// spiking_rate_decoder: counts spikes over a fixed window and presents a thresholded decision
// through a valid/ready handshake.
module spiking_rate_decoder #(
  parameter int WINDOW    = 16,
  parameter int CNT_WIDTH = 5,
  parameter int THRESHOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 spike_in,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] spike_count,
  output logic                 decision
);
  localparam int TW = WINDOW > 1 ? $clog2(WINDOW) : 1;
  localparam logic [CNT_WIDTH-1:0] TH = CNT_WIDTH'(THRESHOLD);
  localparam logic [CNT_WIDTH-1:0] MAX = '1;
  localparam logic [TW-1:0] LAST = TW'(WINDOW - 1);
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
  state_t st, nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_inc;
  logic [TW-1:0] tmr;
  logic accept, done;
  always_comb begin
    accept  = start && (st == IDLE || (st == HOLD && out_ready));
    done    = st == COUNT && tmr == LAST;
    cnt_inc = (spike_in && cnt != MAX) ? cnt + 1'b1 : cnt;
    nxt     = accept ? COUNT : done ? HOLD : (st == HOLD && out_ready) ? IDLE : st;
  end
  // busy/out_valid are decoded from the state register only, so no input reaches them combinationally
  assign busy      = st != IDLE;
  assign out_valid = st == HOLD;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      cnt         <= '0;
      tmr         <= '0;
      spike_count <= '0;
      decision    <= 1'b0;
    end else begin
      st <= nxt;
      if (accept) begin
        cnt <= '0;
        tmr <= '0;
      end else if (st == COUNT) begin
        cnt <= cnt_inc;
        tmr <= tmr + 1'b1;
      end
      if (done) begin
        spike_count <= cnt_inc;
        decision    <= cnt_inc >= TH;
      end
    end
  end
endmodule

// File: tb/tb_spiking_rate_decoder.sv
// tb_spiking_rate_decoder: directed self-checking bench for spiking_rate_decoder.
module tb_spiking_rate_decoder;
  logic clk = 0, rst_n = 0, start = 0, spike_in = 0, out_ready = 0;
  logic busy, out_valid, decision, busy2, valid2, dec2;
  logic [4:0] spike_count;
  logic [2:0] count2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  spiking_rate_decoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .spike_in(spike_in), .out_ready(out_ready),
    .busy(busy), .out_valid(out_valid), .spike_count(spike_count), .decision(decision)
  );

  spiking_rate_decoder #(.WINDOW(16), .CNT_WIDTH(3), .THRESHOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .spike_in(spike_in), .out_ready(out_ready),
    .busy(busy2), .out_valid(valid2), .spike_count(count2), .decision(dec2)
  );

  task cyc;
    @(posedge clk);
    #1;
  endtask

  task run(input logic [15:0] pat, input logic pre);
    start = 1; spike_in = pre; cyc(); start = 0;
    for (int i = 0; i < 16; i++) begin spike_in = pat[i]; cyc(); end
    spike_in = 0;
  endtask

  task accept;
    out_ready = 1; cyc(); out_ready = 0;
  endtask

  task test_reset;
    rst_n = 0;
    start = 1'($urandom); spike_in = 1'($urandom); out_ready = 1'($urandom);
    repeat (3) cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    total++; if (spike_count !== 5'd0) begin bad++; $display("FAIL reset_count got %0d want 0", spike_count); end
    total++; if (decision !== 1'b0) begin bad++; $display("FAIL reset_dec got %0b want 0", decision); end
    start = 0; spike_in = 0; out_ready = 0; rst_n = 1;
    repeat (3) cyc();
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_state got busy=%0b valid=%0b want 0 0", busy, out_valid); end
    total++; if (spike_count !== 5'd0 || decision !== 1'b0) begin bad++; $display("FAIL post_reset_out got %0d/%0b want 0/0", spike_count, decision); end
  endtask

  task test_zero_full;
    int n;
    start = 1; cyc(); start = 0;
    n = 0;
    while (!out_valid && n < 40) begin cyc(); n++; end
    total++; if (n !== 16) begin bad++; $display("FAIL zero_latency got %0d want 16", n); end
    total++; if (spike_count !== 5'd0 || decision !== 1'b0) begin bad++; $display("FAIL zero_result got %0d/%0b want 0/0", spike_count, decision); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy got %0b want 1", busy); end
    accept();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL accept_idle got valid=%0b busy=%0b want 0 0", out_valid, busy); end
    run(16'hFFFF, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid got %0b want 1", out_valid); end
    total++; if (spike_count !== 5'd16 || decision !== 1'b1) begin bad++; $display("FAIL full_result got %0d/%0b want 16/1", spike_count, decision); end
    accept();
  endtask

  task test_threshold;
    run(16'h8421, 1'b0);
    total++; if (spike_count !== 5'd4 || decision !== 1'b1) begin bad++; $display("FAIL thr4 got %0d/%0b want 4/1", spike_count, decision); end
    accept();
    run(16'h0124, 1'b0);
    total++; if (spike_count !== 5'd3 || decision !== 1'b0) begin bad++; $display("FAIL thr3 got %0d/%0b want 3/0", spike_count, decision); end
    accept();
    run(16'h0124, 1'b1);
    spike_in = 1; cyc(); spike_in = 0;
    total++; if (spike_count !== 5'd3 || decision !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL edge_spikes got %0d/%0b valid=%0b want 3/0 1", spike_count, decision, out_valid); end
    accept();
  endtask

  task test_back_to_back;
    run(16'h1111 | 16'h0002, 1'b0);
    total++; if (spike_count !== 5'd5 || decision !== 1'b1) begin bad++; $display("FAIL bp_first got %0d/%0b want 5/1", spike_count, decision); end
    spike_in = 1;
    for (int i = 0; i < 5; i++) begin
      start = 1'(i % 2); cyc();
      total++; if (out_valid !== 1'b1 || spike_count !== 5'd5 || decision !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got valid=%0b %0d/%0b want 1 5/1", i, out_valid, spike_count, decision); end
    end
    spike_in = 0; start = 1; out_ready = 1; cyc(); start = 0; out_ready = 0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_start got valid=%0b busy=%0b want 0 1", out_valid, busy); end
    total++; if (spike_count !== 5'd5) begin bad++; $display("FAIL b2b_keep got %0d want 5", spike_count); end
    for (int i = 0; i < 16; i++) begin spike_in = (i == 3 || i == 10); cyc(); end
    spike_in = 0;
    total++; if (out_valid !== 1'b1 || spike_count !== 5'd2 || decision !== 1'b0) begin bad++; $display("FAIL b2b_second got valid=%0b %0d/%0b want 1 2/0", out_valid, spike_count, decision); end
    accept();
  endtask

  task test_reset_mid;
    start = 1; cyc(); start = 0; spike_in = 1;
    repeat (8) cyc();
    rst_n = 0; #2;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || spike_count !== 5'd0 || decision !== 1'b0) begin bad++; $display("FAIL mid_reset got busy=%0b valid=%0b %0d/%0b want 0 0 0/0", busy, out_valid, spike_count, decision); end
    rst_n = 1; spike_in = 0; cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_idle got busy=%0b want 0", busy); end
    run(16'h5500 | 16'h0001, 1'b0);
    total++; if (spike_count !== 5'd5 || decision !== 1'b1) begin bad++; $display("FAIL after_reset got %0d/%0b want 5/1", spike_count, decision); end
    accept();
  endtask

  task test_saturation;
    run(16'hFFFF, 1'b0);
    total++; if (valid2 !== 1'b1 || count2 !== 3'd7 || dec2 !== 1'b1) begin bad++; $display("FAIL sat got valid=%0b %0d/%0b want 1 7/1", valid2, count2, dec2); end
    total++; if (spike_count !== 5'd16) begin bad++; $display("FAIL sat_main got %0d want 16", spike_count); end
    accept();
  endtask

  initial begin
    test_reset();
    test_zero_full();
    test_threshold();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
